// File: rtl/event_priority_encoder.sv
// Sticky event collector: latches up to N_IN request lines into a pending register and
// presents them one at a time as binary codes on a valid/ready output.
module event_priority_encoder #(
    parameter int N_IN        = 8,
    parameter int W_CODE      = 3,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   evt_in,
    input  logic              clr,
    output logic [W_CODE-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-1:0]   pending,
    output logic              overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e              state_q,    state_d;
    logic [N_IN-1:0]     pending_q,  pending_d;
    logic [W_CODE-1:0]   code_q,     code_d;
    logic                valid_q,    valid_d;
    logic                overflow_q, overflow_d;
    logic [W_CODE-1:0]   last_q,     last_d;

    logic [W_CODE-1:0]   sel_fixed;
    logic [W_CODE-1:0]   sel_rr;
    logic [W_CODE-1:0]   sel;
    logic                any_pending;
    logic                load;
    logic [N_IN-1:0]     load_clr;

    // Descending scan so the lowest set index is the last one written.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    always_comb begin
        sel_fixed = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_fixed = W_CODE'(i);
            end
        end
    end

    // Round-robin: offsets N_IN down to 1 from last_q, so the nearest index after last_q
    // wins and last_q itself is considered last. Code width wraps the index modulo N_IN.
    always_comb begin
        logic [W_CODE-1:0] idx;
        idx    = '0;
        sel_rr = last_q;
        for (int k = N_IN; k >= 1; k--) begin
            idx = last_q + W_CODE'(k);
            if (pending_q[idx]) begin
                sel_rr = idx;
            end
        end
    end

    assign sel         = ROUND_ROBIN ? sel_rr : sel_fixed;
    assign any_pending = |pending_q;
    assign load        = any_pending && ((state_q == IDLE) || (valid_q && out_ready));
    assign load_clr    = load ? (N_IN'(1) << sel) : '0;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        valid_d    = valid_q;
        last_d     = last_q;
        pending_d  = (pending_q & ~load_clr) | evt_in;
        overflow_d = overflow_q | (|(evt_in & pending_q & ~load_clr));

        if (clr) begin
            // Clear discards this cycle's events and any in-flight handshake; last_q survives.
            state_d    = IDLE;
            code_d     = '0;
            valid_d    = 1'b0;
            pending_d  = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d = PRESENT;
                        code_d  = sel;
                        valid_d = 1'b1;
                        last_d  = sel;
                    end
                end
                PRESENT: begin
                    if (load) begin
                        code_d = sel;
                        last_d = sel;
                    end else if (valid_q && out_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            last_q     <= W_CODE'(N_IN - 1);
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_priority_encoder.sv
// Drives a fixed-priority and a round-robin instance with shared stimulus and compares
// both against a per-cycle behavioural model, plus literal expectations for key scenarios.
module tb_event_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] evt_in;
    logic       clr;
    logic       out_ready;

    logic [2:0] fp_code, rr_code;
    logic       fp_valid, rr_valid;
    logic [7:0] fp_pend, rr_pend;
    logic       fp_ovf, rr_ovf;

    int n_vec = 0;
    int n_bad = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    bit [7:0] m_pend [2];
    bit       m_valid[2];
    bit [2:0] m_code [2];
    bit       m_ovf  [2];
    int       m_last [2];
    int       dq0[$];
    int       dq1[$];

    always #5 clk = ~clk;

    event_priority_encoder #(.N_IN(8), .W_CODE(3), .ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .clr(clr),
        .out_code(fp_code), .out_valid(fp_valid), .out_ready(out_ready),
        .pending(fp_pend), .overflow(fp_ovf)
    );

    event_priority_encoder #(.N_IN(8), .W_CODE(3), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .clr(clr),
        .out_code(rr_code), .out_valid(rr_valid), .out_ready(out_ready),
        .pending(rr_pend), .overflow(rr_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = '0;
            m_valid[k] = 1'b0;
            m_code[k]  = '0;
            m_ovf[k]   = 1'b0;
            m_last[k]  = 7;
        end
    endtask

    // One clock edge of the behavioural model, from the inputs stable at that edge.
    task automatic model_step(input int k);
        int sel;
        bit ld;
        if (clr) begin
            m_pend[k]  = '0;
            m_ovf[k]   = 1'b0;
            m_valid[k] = 1'b0;
            m_code[k]  = '0;
            return;
        end
        if (m_valid[k] && out_ready) begin
            if (k == 0) dq0.push_back(int'(m_code[k]));
            else        dq1.push_back(int'(m_code[k]));
        end
        ld  = (m_pend[k] != 0) && (!m_valid[k] || out_ready);
        sel = -1;
        if (ld) begin
            if (k == 0) begin
                for (int i = 0; i < 8; i++)
                    if (m_pend[k][i]) begin sel = i; break; end
            end else begin
                for (int j = 1; j <= 8; j++) begin
                    int i;
                    i = (m_last[k] + j) % 8;
                    if (m_pend[k][i]) begin sel = i; break; end
                end
            end
        end
        for (int i = 0; i < 8; i++)
            if (evt_in[i] && m_pend[k][i] && i != sel) m_ovf[k] = 1'b1;
        if (ld) m_pend[k][sel] = 1'b0;
        m_pend[k] = m_pend[k] | evt_in;
        if (ld) begin
            m_valid[k] = 1'b1;
            m_code[k]  = 3'(sel);
            m_last[k]  = sel;
        end else if (m_valid[k] && out_ready) begin
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("fp valid",    32'(fp_valid), 32'(m_valid[0]));
        check("fp pending",  32'(fp_pend),  32'(m_pend[0]));
        check("fp overflow", 32'(fp_ovf),   32'(m_ovf[0]));
        if (m_valid[0]) check("fp code", 32'(fp_code), 32'(m_code[0]));
        check("rr valid",    32'(rr_valid), 32'(m_valid[1]));
        check("rr pending",  32'(rr_pend),  32'(m_pend[1]));
        check("rr overflow", 32'(rr_ovf),   32'(m_ovf[1]));
        if (m_valid[1]) check("rr code", 32'(rr_code), 32'(m_code[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    // Asserts reset between edges and checks the outputs fall before any clock edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst fp code",  32'(fp_code),  0);
        check("rst fp valid", 32'(fp_valid), 0);
        check("rst fp pend",  32'(fp_pend),  0);
        check("rst fp ovf",   32'(fp_ovf),   0);
        check("rst rr valid", 32'(rr_valid), 0);
        check("rst rr pend",  32'(rr_pend),  0);
        rst_n = 1'b1;
    endtask

    initial begin
        // NOTE: bench drives inputs with blocking assignments between clock edges.
        rst_n     = 1'b0;
        evt_in    = '0;
        clr       = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;

        // Reset mid-PRESENT with everything pending.
        evt_in = 8'hFF;
        tick();
        tick();
        evt_in = '0;
        check("t1 pend before rst",  32'(fp_pend),  32'h0FF);
        check("t1 valid before rst", 32'(fp_valid), 1);
        async_reset();

        // Single event: code 5 two edges later, for one cycle.
        out_ready = 1'b1;
        evt_in    = 8'b0010_0000;
        tick();
        evt_in = '0;
        check("t2 not yet valid", 32'(fp_valid), 0);
        tick();
        check("t2 fp code",  32'(fp_code),  5);
        check("t2 fp valid", 32'(fp_valid), 1);
        check("t2 rr code",  32'(rr_code),  5);
        tick();
        check("t2 valid drop", 32'(fp_valid), 0);
        check("t2 pend zero",  32'(fp_pend),  0);

        // Multi-hot: fixed gives 0,2,7; round-robin after serving 5 gives 7,0,2.
        dq0.delete();
        dq1.delete();
        evt_in = 8'b1000_0101;
        tick();
        evt_in = '0;
        repeat (5) tick();
        check("t3 fp count", 32'(dq0.size()), 3);
        check("t3 fp 0", 32'(dq0[0]), 0);
        check("t3 fp 1", 32'(dq0[1]), 2);
        check("t3 fp 2", 32'(dq0[2]), 7);
        check("t3 rr count", 32'(dq1.size()), 3);
        check("t3 rr 0", 32'(dq1[0]), 7);
        check("t3 rr 1", 32'(dq1[1]), 0);
        check("t3 rr 2", 32'(dq1[2]), 2);
        check("t3 idle", 32'(fp_valid), 0);

        // Backpressure: code 3 held while event 1 pends.
        out_ready = 1'b0;
        evt_in    = 8'b0000_1000;
        tick();
        evt_in = '0;
        tick();
        evt_in = 8'b0000_0010;
        tick();
        evt_in = '0;
        tick();
        check("t4 held code", 32'(fp_code), 3);
        check("t4 held pend", 32'(fp_pend), 32'h02);
        check("t4 rr held",   32'(rr_code), 3);
        out_ready = 1'b1;
        tick();
        check("t4 next code",  32'(fp_code),  1);
        check("t4 next valid", 32'(fp_valid), 1);
        tick();
        check("t4 drained", 32'(fp_valid), 0);

        // Overflow and coalescing: code 3 stalls while event 4 arrives twice.
        out_ready = 1'b0;
        evt_in    = 8'b0001_1000;
        tick();
        evt_in = '0;
        tick();
        evt_in = 8'b0001_0000;
        tick();
        evt_in = '0;
        tick();
        evt_in = 8'b0001_0000;
        tick();
        evt_in = '0;
        check("t5 overflow", 32'(fp_ovf),  1);
        check("t5 pend",     32'(fp_pend), 32'h10);
        dq0.delete();
        dq1.delete();
        out_ready = 1'b1;
        repeat (4) tick();
        check("t5 count",   32'(dq0.size()), 2);
        check("t5 first",   32'(dq0[0]), 3);
        check("t5 second",  32'(dq0[1]), 4);
        check("t5 ovf sticky", 32'(fp_ovf), 1);

        // Clear beats everything, including events in the same cycle.
        out_ready = 1'b0;
        evt_in    = 8'b0000_1100;
        tick();
        evt_in = 8'b0000_1000;
        tick();
        clr       = 1'b1;
        evt_in    = 8'hFF;
        out_ready = 1'b1;
        tick();
        clr    = 1'b0;
        evt_in = '0;
        check("t5 clr pend",  32'(fp_pend),  0);
        check("t5 clr ovf",   32'(fp_ovf),   0);
        check("t5 clr valid", 32'(fp_valid), 0);
        tick();
        check("t5 clr discard", 32'(fp_valid), 0);

        // All lines held: round-robin rotates from 0, fixed priority always 0.
        async_reset();
        dq0.delete();
        dq1.delete();
        evt_in = 8'hFF;
        repeat (20) tick();
        evt_in = '0;
        check("t6 count", 32'(dq0.size()), 18);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6 fp %0d", i), 32'(dq0[i]), 0);
            check($sformatf("t6 rr %0d", i), 32'(dq1[i]), 32'(i % 8));
        end

        // Randomized traffic with occasional clear and asynchronous reset.
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 3))
                0:       evt_in = 8'($urandom);
                1:       evt_in = 8'(1 << $urandom_range(0, 7));
                default: evt_in = '0;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 60) == 0);
            tick();
            if ($urandom_range(0, 300) == 0) async_reset();
        end
        clr    = 1'b0;
        evt_in = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
